// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-driven add/subtract sequencer in front of an external ALU
//
// Purpose:
//   Collects up to three decimal digits for each of two operands from a
//   keypad, hands the pair to an external ALU, and shows the operands or
//   the result on a display register. Subtraction with A < B is refused
//   locally. An ALU that never answers is abandoned after 256 cycles.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   key_valid   in   one pulse per key press
//   key_code    in   0-9 digit, A add, B subtract, C clear, E equals, D/F ignored
//   alu_start   out  one-cycle request, first cycle of WAIT_ALU
//   alu_op      out  0 add, 1 subtract
//   op_a, op_b  out  binary operands, stable while WAIT_ALU
//   alu_done    in   one-cycle completion pulse
//   alu_result  in   result, valid with alu_done
//   disp_value  out  displayed value
//   busy        out  high in WAIT_ALU
//   err         out  high in ERROR
//   state       out  debug state code

module calc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        alu_start,
  output logic        alu_op,
  output logic [9:0]  op_a,
  output logic [9:0]  op_b,
  input  logic        alu_done,
  input  logic [13:0] alu_result,
  output logic [13:0] disp_value,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_WAIT_ALU = 3'd2,
    ST_SHOW_RES = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  a_q, a_d;
  logic [9:0]  b_q, b_d;
  logic [1:0]  a_cnt_q, a_cnt_d;
  logic [1:0]  b_cnt_q, b_cnt_d;
  logic        op_q, op_d;
  logic        alu_start_q, alu_start_d;
  logic [9:0]  op_a_q, op_a_d;
  logic [9:0]  op_b_q, op_b_d;
  logic [13:0] res_q, res_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [13:0] disp_q, disp_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic key_live;
  logic is_digit;
  logic is_op;
  logic is_clr;
  logic is_eq;

  // v*10 + d; callers only append while fewer than 3 digits are held,
  // so the result never exceeds 999 and fits the operand width.
  function automatic logic [9:0] append_digit(input logic [9:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + {6'd0, d};
  endfunction

  always_comb begin
    key_live = key_valid && (key_code != 4'hD) && (key_code != 4'hF);
    is_digit = key_live && (key_code <= 4'd9);
    is_op    = key_live && ((key_code == 4'hA) || (key_code == 4'hB));
    is_clr   = key_live && (key_code == 4'hC);
    is_eq    = key_live && (key_code == 4'hE);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    op_d        = op_q;
    alu_start_d = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    tmo_d       = tmo_q;

    if (is_clr) begin
      // Clear has priority over everything, including an ALU answer
      // arriving in the same cycle.
      state_d = ST_ENTER_A;
      a_d     = 10'd0;
      b_d     = 10'd0;
      a_cnt_d = 2'd0;
      b_cnt_d = 2'd0;
      op_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (is_digit) begin
            if (a_cnt_q != 2'd3) begin
              a_d     = append_digit(a_q, key_code);
              a_cnt_d = a_cnt_q + 2'd1;
            end
          end else if (is_op) begin
            op_d    = key_code[0];
            b_d     = 10'd0;
            b_cnt_d = 2'd0;
            state_d = ST_ENTER_B;
          end
        end

        ST_ENTER_B: begin
          if (is_digit) begin
            if (b_cnt_q != 2'd3) begin
              b_d     = append_digit(b_q, key_code);
              b_cnt_d = b_cnt_q + 2'd1;
            end
          end else if (is_op) begin
            // Operator can still be changed until B has a digit.
            if (b_cnt_q == 2'd0) begin
              op_d = key_code[0];
            end
          end else if (is_eq) begin
            if (op_q && (a_q < b_q)) begin
              state_d = ST_ERROR;
            end else begin
              state_d     = ST_WAIT_ALU;
              alu_start_d = 1'b1;
              op_a_d      = a_q;
              op_b_d      = b_q;
              tmo_d       = 8'd0;
            end
          end
        end

        ST_WAIT_ALU: begin
          // The start cycle itself counts, so a done coincident with
          // alu_start is taken here like any other.
          if (alu_done) begin
            res_d   = alu_result;
            state_d = ST_SHOW_RES;
          end else if (tmo_q == 8'hFF) begin
            state_d = ST_ERROR;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end

        ST_SHOW_RES, ST_ERROR: begin
          if (is_digit) begin
            a_d     = {6'd0, key_code};
            a_cnt_d = 2'd1;
            b_d     = 10'd0;
            b_cnt_d = 2'd0;
            op_d    = 1'b0;
            state_d = ST_ENTER_A;
          end
        end

        default: begin
          state_d = ST_ENTER_A;
        end
      endcase
    end

    // Display and status follow the next state so they change on the
    // same edge as the key that caused them.
    case (state_d)
      ST_ENTER_A:  disp_d = {4'd0, a_d};
      ST_ENTER_B:  disp_d = (b_cnt_d != 2'd0) ? {4'd0, b_d} : {4'd0, a_d};
      ST_WAIT_ALU: disp_d = {4'd0, a_d};
      ST_SHOW_RES: disp_d = res_d;
      default:     disp_d = 14'd0;
    endcase
    busy_d = (state_d == ST_WAIT_ALU);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ENTER_A;
      a_q         <= 10'd0;
      b_q         <= 10'd0;
      a_cnt_q     <= 2'd0;
      b_cnt_q     <= 2'd0;
      op_q        <= 1'b0;
      alu_start_q <= 1'b0;
      op_a_q      <= 10'd0;
      op_b_q      <= 10'd0;
      res_q       <= 14'd0;
      tmo_q       <= 8'd0;
      disp_q      <= 14'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      op_q        <= op_d;
      alu_start_q <= alu_start_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      tmo_q       <= tmo_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign alu_start  = alu_start_q;
  assign alu_op     = op_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign disp_value = disp_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule
